// File: rtl/fuzz_stim_sig_pkg.sv
// fuzz_pkg: shared polynomials, default seed and FSM encoding for the stimulus/signature harness
package fuzz_pkg;
  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED = 32'hACE10001;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/fuzz_stim_sig_misr_fold.sv
// misr_fold: folds a wide response into 32 bits and compacts it into a MISR
module misr_fold
  import fuzz_pkg::*;
#(
  parameter int unsigned Y_W = 53
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_clr,
  input  logic           i_en,
  input  logic [Y_W-1:0] i_y,
  output logic [31:0]    o_misr
);
  logic [31:0] w_fold;
  assign w_fold = i_y[31:0] ^ 32'(i_y[Y_W-1:32]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) o_misr <= '0;
    else o_misr <= i_clr ? '0
                 : i_en ? {o_misr[30:0], 1'b0} ^ (o_misr[31] ? MISR_POLY : 32'd0) ^ w_fold
                 : o_misr;
endmodule

// File: rtl/fuzz_stim_sig.sv
// fuzz_stim_sig: seeded LFSR vector driver with MISR signature of the latency-delayed response
module fuzz_stim_sig
  import fuzz_pkg::*;
#(
  parameter int unsigned LAT      = 0,
  parameter logic [31:0] DEF_SEED = fuzz_pkg::DEF_SEED,
  parameter int unsigned Y_W      = 53
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [31:0]    seed,
  input  logic [15:0]    num_vec,
  output logic           busy,
  output logic           done,
  output logic [31:0]    signature,
  output logic [9:0]     dut_wire0,
  output logic [7:0]     dut_wire1,
  input  logic [Y_W-1:0] dut_y
);
  localparam logic [2:0] LAST_DRAIN = LAT == 0 ? 3'd0 : 3'(LAT - 1);
  state_t      r_state;
  logic [31:0] r_lfsr;
  logic [15:0] r_num, r_cnt;
  logic [2:0]  r_drain;
  logic [LAT:0] r_pipe;
  logic        w_accept, w_issue;
  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  // vector 0 is registered on the LOAD->RUN edge so each RUN cycle shows one vector on the pins
  assign w_issue = (r_state == LOAD && r_num != 16'd0) || (r_state == RUN && r_cnt != r_num);
  assign busy = r_state == LOAD || r_state == RUN || r_state == DRAIN;
  assign done = r_state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= IDLE;
      r_lfsr    <= '0;
      r_num     <= '0;
      r_cnt     <= '0;
      r_drain   <= '0;
      r_pipe    <= '0;
      dut_wire0 <= '0;
      dut_wire1 <= '0;
    end else begin
      r_pipe <= (r_pipe << 1) | (LAT + 1)'(w_issue);
      if (w_issue) begin
        r_cnt     <= r_cnt + 16'd1;
        dut_wire0 <= r_lfsr[9:0];
        dut_wire1 <= r_lfsr[17:10];
        r_lfsr    <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_POLY : 32'd0);
      end
      case (r_state)
        IDLE, DONE: if (start) begin
          r_state <= LOAD;
          r_num   <= num_vec;
          r_cnt   <= '0;
          r_lfsr  <= seed == 32'd0 ? DEF_SEED : seed;
        end
        LOAD: r_state <= r_num == 16'd0 ? DONE : RUN;
        RUN: if (r_cnt == r_num) begin
          r_state <= LAT == 0 ? DONE : DRAIN;
          r_drain <= '0;
        end
        DRAIN: if (r_drain == LAST_DRAIN) r_state <= DONE;
               else r_drain <= r_drain + 3'd1;
        default: r_state <= IDLE;
      endcase
    end
  misr_fold #(.Y_W(Y_W)) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_accept),
    .i_en   (r_pipe[LAT]),
    .i_y    (dut_y),
    .o_misr (signature)
  );
endmodule
